// File: rtl/if_id_stage.sv
// IF/ID pipeline register: captures the fetched PC+1 and instruction, supports
// load-use hold and branch squash, decodes J-type jumps, and counts hold and
// squash events with saturating counters.
module if_id_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic        if_id_write,
  input  logic        flush,
  output logic [31:0] pc_plus1_out,
  output logic [31:0] instr_out,
  output logic        valid_out,
  output logic        jump_out,
  output logic [31:0] jump_address_out,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam logic [5:0]  OpJump = 6'b000010;
  localparam logic [15:0] CntMax = 16'hFFFF;

  typedef enum logic [0:0] {StEmpty, StLive} state_e;

  state_e      state_q;
  logic [31:0] pc_plus1_q;
  logic [31:0] instr_q;
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  // Register update; flush beats stall beats capture. instr_in is never
  // sampled on a flush or stall, so X there cannot reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      pc_plus1_q  <= '0;
      instr_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (flush) begin
      state_q    <= StEmpty;
      pc_plus1_q <= pc_in + 32'd1;
      instr_q    <= '0;
      if (flush_cnt_q != CntMax) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end else if (!if_id_write) begin
      if (stall_cnt_q != CntMax) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end else begin
      state_q    <= StLive;
      pc_plus1_q <= pc_in + 32'd1;
      instr_q    <= instr_in;
    end
  end

  // Outputs driven straight from the registers; jump decode in the same cycle.
  always_comb begin
    pc_plus1_out     = pc_plus1_q;
    instr_out        = instr_q;
    valid_out        = (state_q == StLive);
    jump_out         = valid_out && (instr_q[31:26] == OpJump);
    jump_address_out = {pc_plus1_q[31:26], instr_q[25:0]};
    stall_cnt        = stall_cnt_q;
    flush_cnt        = flush_cnt_q;
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage with hand-computed expected values.
module tb_if_id_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_in;
  logic [31:0] instr_in;
  logic        if_id_write;
  logic        flush;
  logic [31:0] pc_plus1_out;
  logic [31:0] instr_out;
  logic        valid_out;
  logic        jump_out;
  logic [31:0] jump_address_out;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  if_id_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_in            (pc_in),
    .instr_in         (instr_in),
    .if_id_write      (if_id_write),
    .flush            (flush),
    .pc_plus1_out     (pc_plus1_out),
    .instr_out        (instr_out),
    .valid_out        (valid_out),
    .jump_out         (jump_out),
    .jump_address_out (jump_address_out),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle away from it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic vld, input logic jmp, input logic [31:0] jaddr,
                           input logic [15:0] sc, input logic [15:0] fc);
    check_eq({tag, ".pc"},    pc_plus1_out, pc);
    check_eq({tag, ".instr"}, instr_out, ins);
    check_eq({tag, ".valid"}, {31'd0, valid_out}, {31'd0, vld});
    check_eq({tag, ".jump"},  {31'd0, jump_out}, {31'd0, jmp});
    check_eq({tag, ".jaddr"}, jump_address_out, jaddr);
    check_eq({tag, ".scnt"},  {16'd0, stall_cnt}, {16'd0, sc});
    check_eq({tag, ".fcnt"},  {16'd0, flush_cnt}, {16'd0, fc});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    pc_in       = '0;
    instr_in    = '0;
    if_id_write = 1'b0;
    flush       = 1'b0;
    #3;
    check_all("reset", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 16'd0, 16'd0);
    #4 rst_n = 1'b1;

    // Plain capture (addi opcode, not a jump).
    pc_in = 32'd5; instr_in = 32'h2002000A; if_id_write = 1'b1;
    tick();
    check_all("capture", 32'd6, 32'h2002000A, 1'b1, 1'b0, 32'h0002000A, 16'd0, 16'd0);

    // Three hold cycles with changing and unknown instruction input.
    if_id_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pc_in    = 32'h100 + i;
      instr_in = (i == 1) ? 32'hxxxxxxxx : 32'hDEAD0000 + i;
      tick();
    end
    check_all("stall", 32'd6, 32'h2002000A, 1'b1, 1'b0, 32'h0002000A, 16'd3, 16'd0);

    // J-type capture.
    pc_in = 32'h0400000F; instr_in = 32'h08000040; if_id_write = 1'b1;
    tick();
    check_all("jump", 32'h04000010, 32'h08000040, 1'b1, 1'b1, 32'h04000040, 16'd3, 16'd0);

    // Flush and stall on the same edge: flush wins, X instr ignored.
    flush = 1'b1; if_id_write = 1'b0; instr_in = 32'hxxxxxxxx;
    tick();
    check_all("prio", 32'h04000010, 32'h0, 1'b0, 1'b0, 32'h04000000, 16'd3, 16'd1);

    // Stall while empty still counts.
    flush = 1'b0; pc_in = 32'h20;
    tick();
    check_all("stall_empty", 32'h04000010, 32'h0, 1'b0, 1'b0, 32'h04000000, 16'd4, 16'd1);

    // Flush with write asserted.
    flush = 1'b1; if_id_write = 1'b1; pc_in = 32'h7;
    tick();
    check_all("flush_wr", 32'h8, 32'h0, 1'b0, 1'b0, 32'h0, 16'd4, 16'd2);

    // PC wrap on a jump capture.
    flush = 1'b0; pc_in = 32'hFFFFFFFF; instr_in = 32'h08000001;
    tick();
    check_all("wrap", 32'h0, 32'h08000001, 1'b1, 1'b1, 32'h00000001, 16'd4, 16'd2);

    // Asynchronous reset between edges while live.
    #2 rst_n = 1'b0;
    #1;
    check_all("async_rst", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 16'd0, 16'd0);
    #1 rst_n = 1'b1;

    // Capture after reset, then saturate the stall counter.
    pc_in = 32'h40; instr_in = 32'h00000123; if_id_write = 1'b1;
    tick();
    check_all("recap", 32'h41, 32'h00000123, 1'b1, 1'b0, 32'h00000123, 16'd0, 16'd0);
    if_id_write = 1'b0; instr_in = 32'hxxxxxxxx;
    for (int i = 0; i < 65540; i++) begin
      tick();
      if (i == 65533) begin
        check_eq("sat_pre", {16'd0, stall_cnt}, 32'h0000FFFE);
      end
    end
    check_all("sat", 32'h41, 32'h00000123, 1'b1, 1'b0, 32'h00000123, 16'hFFFF, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
